sweep_tracker: RTL and testbench

//  Parametrised two-axis sweep/peak tracker for the panel optimizer: replaces fixed FSM+counters+FF_Array.

---
 rtl/sweep_tracker.sv | 169 ++++++++++++++++
 tb/tb_sweep_tracker.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_tracker.sv
// Two-axis sweep/peak tracker: steps H then V across [POS_MIN,POS_MAX], settles,
// samples the ADC once per step and keeps the largest sample with its position.
module sweep_tracker #(
    parameter int ADC_W   = 12,
    parameter int POS_W   = 32,
    parameter int POS_MIN = 50000,
    parameter int POS_MAX = 250000,
    parameter int STEP    = 1000,
    parameter int SETTLE  = 24414,
    parameter int HYST    = 0,
    parameter int TIMEOUT = 100000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic             ADC_VALID,
    input  logic [ADC_W-1:0] ADC_DATA,
    output logic [POS_W-1:0] POS_H,
    output logic [POS_W-1:0] POS_V,
    output logic [ADC_W-1:0] MAX_V,
    output logic             AXIS,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [2:0]       STAT
);

    localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [POS_W-1:0] POS_MIN_P   = POS_W'(POS_MIN);
    localparam logic [POS_W:0]   POS_MAX_X   = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   STEP_X      = (POS_W+1)'(STEP);
    localparam logic [ADC_W:0]   HYST_X      = (ADC_W+1)'(HYST);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_STEP   = 3'd3,
        S_NEXT   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t           state_reg;
    logic [POS_W-1:0] pos_h_reg, pos_v_reg;
    logic [POS_W-1:0] best_h_reg, best_v_reg;
    logic [ADC_W-1:0] max_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             axis_reg, busy_reg, done_reg, err_reg, first_reg;

    logic [POS_W:0]   step_sum;
    logic             sample_wins;

    // One bit of headroom on both sums so neither the step nor the hysteresis threshold wraps.
    always_comb begin
        step_sum    = (axis_reg ? {1'b0, pos_v_reg} : {1'b0, pos_h_reg}) + STEP_X;
        sample_wins = first_reg || ({1'b0, ADC_DATA} > ({1'b0, max_reg} + HYST_X));
    end

    always_ff @(posedge CLK) begin
        done_reg <= 1'b0;
        if (RESET) begin
            state_reg  <= S_IDLE;
            pos_h_reg  <= POS_MIN_P;
            pos_v_reg  <= POS_MIN_P;
            best_h_reg <= POS_MIN_P;
            best_v_reg <= POS_MIN_P;
            max_reg    <= '0;
            cnt_reg    <= '0;
            axis_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
            first_reg  <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (START) begin
                state_reg  <= S_SETTLE;
                pos_h_reg  <= POS_MIN_P;
                pos_v_reg  <= POS_MIN_P;
                best_h_reg <= POS_MIN_P;
                best_v_reg <= POS_MIN_P;
                max_reg    <= '0;
                cnt_reg    <= '0;
                axis_reg   <= 1'b0;
                busy_reg   <= 1'b1;
                err_reg    <= 1'b0;
                first_reg  <= 1'b1;
            end
        end else if (ABORT) begin
            // Positions and peak stay frozen where the sweep was interrupted.
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                S_SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= S_SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                S_SAMPLE: begin
                    if (ADC_VALID) begin
                        if (sample_wins) begin
                            max_reg <= ADC_DATA;
                            if (axis_reg) best_v_reg <= pos_v_reg;
                            else          best_h_reg <= pos_h_reg;
                        end
                        first_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_STEP;
                    end else if (cnt_reg == TMO_LAST) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                S_STEP: begin
                    if (step_sum <= POS_MAX_X) begin
                        if (axis_reg) pos_v_reg <= step_sum[POS_W-1:0];
                        else          pos_h_reg <= step_sum[POS_W-1:0];
                        state_reg <= S_SETTLE;
                    end else begin
                        state_reg <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // POS_MIN on V was already covered by the H sweep, so V resumes via STEP.
                    if (!axis_reg) begin
                        pos_h_reg <= best_h_reg;
                        axis_reg  <= 1'b1;
                        state_reg <= S_STEP;
                    end else begin
                        pos_v_reg <= best_v_reg;
                        done_reg  <= 1'b1;
                        state_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign POS_H = pos_h_reg;
    assign POS_V = pos_v_reg;
    assign MAX_V = max_reg;
    assign AXIS  = axis_reg;
    assign BUSY  = busy_reg;
    assign DONE  = done_reg;
    assign ERR   = err_reg;
    assign STAT  = state_reg;

endmodule

// File: tb/tb_sweep_tracker.sv
// Scoreboard bench for sweep_tracker: two instances (span 0..40 HYST=0, span 0..35 HYST=2)
// driven by a randomised ADC responder and checked against a per-sweep peak model.
module tb_sweep_tracker;

    localparam int N      = 2;
    localparam int PMIN   = 0;
    localparam int STP    = 10;
    localparam int SETTLE = 3;
    localparam int TMO    = 20;

    function automatic int pmax_of(int i);
        return (i == 0) ? 40 : 35;
    endfunction
    function automatic int hyst_of(int i);
        return (i == 0) ? 0 : 2;
    endfunction
    function automatic int npos_of(int i);
        return (pmax_of(i) - PMIN) / STP + 1;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [N];
    logic        abort [N];
    logic        adc_valid [N];
    logic [11:0] adc_data [N];
    logic [31:0] pos_h [N];
    logic [31:0] pos_v [N];
    logic [11:0] max_v [N];
    logic        axis [N];
    logic        busy [N];
    logic        done [N];
    logic        err [N];
    logic [2:0]  stat [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        sweep_tracker #(
            .ADC_W(12), .POS_W(32), .POS_MIN(PMIN),
            .POS_MAX((gi == 0) ? 40 : 35), .STEP(STP), .SETTLE(SETTLE),
            .HYST((gi == 0) ? 0 : 2), .TIMEOUT(TMO)
        ) u_dut (
            .CLK(clk), .RESET(rst), .START(start[gi]), .ABORT(abort[gi]),
            .ADC_VALID(adc_valid[gi]), .ADC_DATA(adc_data[gi]),
            .POS_H(pos_h[gi]), .POS_V(pos_v[gi]), .MAX_V(max_v[gi]),
            .AXIS(axis[gi]), .BUSY(busy[gi]), .DONE(done[gi]), .ERR(err[gi]),
            .STAT(stat[gi])
        );
    end

    typedef struct {
        int inst;
        int h;
        int v;
        int mx;
        int n;
    } exp_t;

    exp_t sb_q[$];
    int   h_vals[$];
    int   v_vals[$];
    int   sample_q[$];
    int   ax_q[$];
    int   pos_q[$];
    int   sel = 0;
    int   consumed = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(string name, longint act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Peak search straight from the sweep rules: H over every grid point, V from POS_MIN+STEP.
    function automatic exp_t model(int inst);
        exp_t e;
        int   n = npos_of(inst);
        int   hy = hyst_of(inst);
        int   best = h_vals[0];
        e.inst = inst;
        e.h    = PMIN;
        for (int k = 1; k < n; k++)
            if (h_vals[k] > best + hy) begin
                best = h_vals[k];
                e.h  = PMIN + k * STP;
            end
        e.v = PMIN;
        for (int k = 1; k < n; k++)
            if (v_vals[k-1] > best + hy) begin
                best = v_vals[k-1];
                e.v  = PMIN + k * STP;
            end
        e.mx = best;
        e.n  = 2 * n - 1;
        return e;
    endfunction

    task automatic fill_random(int inst, int maxval);
        h_vals.delete();
        v_vals.delete();
        for (int k = 0; k < npos_of(inst); k++) h_vals.push_back(int'($urandom_range(0, maxval)));
        for (int k = 1; k < npos_of(inst); k++) v_vals.push_back(int'($urandom_range(0, maxval)));
    endtask

    task automatic load(int inst, int limit);
        sample_q.delete();
        ax_q.delete();
        pos_q.delete();
        for (int k = 0; k < npos_of(inst); k++) begin
            sample_q.push_back(h_vals[k]); ax_q.push_back(0); pos_q.push_back(PMIN + k * STP);
        end
        for (int k = 1; k < npos_of(inst); k++) begin
            sample_q.push_back(v_vals[k-1]); ax_q.push_back(1); pos_q.push_back(PMIN + k * STP);
        end
        while (sample_q.size() > limit) begin
            void'(sample_q.pop_back()); void'(ax_q.pop_back()); void'(pos_q.pop_back());
        end
        sel      = inst;
        consumed = 0;
    endtask

    task automatic flush();
        sample_q.delete();
        ax_q.delete();
        pos_q.delete();
    endtask

    task automatic pulse_start(int inst);
        start[inst] = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
        chk("start_stat", stat[inst], 1);
        chk("start_busy", busy[inst], 1);
        chk("start_err_clr", err[inst], 0);
        chk("start_pos_h", pos_h[inst], PMIN);
        chk("start_pos_v", pos_v[inst], PMIN);
        chk("start_max", max_v[inst], 0);
    endtask

    task automatic run_sweep(int inst);
        int cyc = 0;
        load(inst, 64);
        sb_q.push_back(model(inst));
        @(negedge clk);
        pulse_start(inst);
        while (sb_q.size() > 0 && cyc < 2000) begin
            // START while busy must be ignored; only inject where the next edge is not in IDLE.
            if (stat[inst] inside {3'd1, 3'd2, 3'd3, 3'd4} && $urandom_range(0, 15) == 0)
                start[inst] = 1'b1;
            @(negedge clk);
            start[inst] = 1'b0;
            cyc++;
        end
        chk("sweep_completed", sb_q.size(), 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // ADC responder: one sample per SAMPLE visit after a random delay, plus stray strobes elsewhere.
    initial begin
        int dly = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) adc_valid[i] = 1'b0;
            if (stat[sel] == 3'd2 && sample_q.size() > 0) begin
                if (dly == 0) begin
                    adc_valid[sel] = 1'b1;
                    adc_data[sel]  = 12'(sample_q.pop_front());
                    chk("sample_axis", axis[sel], ax_q.pop_front());
                    chk("sample_pos", axis[sel] ? pos_v[sel] : pos_h[sel], pos_q.pop_front());
                    consumed++;
                    dly = int'($urandom_range(0, 4));
                end else begin
                    dly--;
                end
            end else if (stat[sel] inside {3'd1, 3'd3} && $urandom_range(0, 3) == 0) begin
                adc_valid[sel] = 1'b1;
                adc_data[sel]  = 12'hFFF;
            end
        end
    end

    // Monitor: settle timing, span bound, and DONE against the scoreboard.
    initial begin
        int   cyc = 0;
        int   prev [N];
        int   t_settle [N];
        exp_t e;
        for (int i = 0; i < N; i++) begin
            prev[i] = 0;
            t_settle[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (stat[i] == 3'd1 && prev[i] != 1) begin
                    t_settle[i] = cyc;
                    chk("pos_h_in_span", pos_h[i] <= 32'(pmax_of(i)), 1);
                    chk("pos_v_in_span", pos_v[i] <= 32'(pmax_of(i)), 1);
                end
                if (stat[i] == 3'd2 && prev[i] == 1) chk("settle_cycles", cyc - t_settle[i], SETTLE);
                prev[i] = int'(stat[i]);
                if (done[i]) begin
                    chk("done_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("done_inst", i, e.inst);
                        chk("done_stat", stat[i], 5);
                        chk("final_pos_h", pos_h[i], e.h);
                        chk("final_pos_v", pos_v[i], e.v);
                        chk("final_max_v", max_v[i], e.mx);
                        chk("samples_used", consumed, e.n);
                        $display("[TB] sweep inst=%0d pos_h=%0d pos_v=%0d max_v=%0d samples=%0d",
                                 i, pos_h[i], pos_v[i], max_v[i], consumed);
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        int cnt;
        int exp_mx;
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; adc_valid[i] = 1'b0; adc_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_pos_h", pos_h[i], PMIN);
            chk("rst_pos_v", pos_v[i], PMIN);
            chk("rst_max", max_v[i], 0);
            chk("rst_stat", stat[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_err", err[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_axis", axis[i], 0);
        end

        // Peak sweep from the reference scenario.
        h_vals = '{5, 9, 30, 12, 4};
        v_vals = '{10, 40, 35, 2};
        run_sweep(0);
        // Ties keep the earliest position; second instance adds hysteresis and a ragged span.
        h_vals = '{7, 7, 7, 7, 7};
        v_vals = '{8, 9, 10, 11};
        run_sweep(0);
        h_vals = '{7, 7, 7, 7};
        v_vals = '{8, 9, 10};
        run_sweep(1);

        for (int r = 0; r < 8; r++) begin
            fill_random(r % 2, (r < 4) ? 15 : 4095);
            run_sweep(r % 2);
        end

        // Abort while settling at H=20.
        fill_random(0, 4095);
        load(0, 64);
        pulse_start(0);
        cyc = 0;
        while (!(stat[0] == 3'd1 && pos_h[0] == 32'd20 && axis[0] == 1'b0) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_pos20", pos_h[0], 20);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        flush();
        chk("abort_stat", stat[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_pos_h", pos_h[0], 20);
        chk("abort_done", done[0], 0);
        repeat (10) @(negedge clk);
        fill_random(0, 4095);
        run_sweep(0);

        // ADC timeout at the third H point, then START alone clears ERR.
        fill_random(0, 4095);
        load(0, 2);
        exp_mx = (h_vals[1] > h_vals[0]) ? h_vals[1] : h_vals[0];
        pulse_start(0);
        cyc = 0;
        while (!(stat[0] == 3'd2 && pos_h[0] == 32'd20) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        cnt = 0;
        while (stat[0] == 3'd2 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_cycles", cnt, TMO);
        chk("timeout_err", err[0], 1);
        chk("timeout_stat", stat[0], 0);
        chk("timeout_busy", busy[0], 0);
        chk("timeout_pos_h", pos_h[0], 20);
        chk("timeout_max", max_v[0], exp_mx);
        repeat (3) @(negedge clk);
        chk("err_sticky", err[0], 1);
        fill_random(0, 4095);
        run_sweep(0);

        // START and ABORT together in IDLE: START wins.
        flush();
        sel = 1;
        start[1] = 1'b1;
        abort[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        abort[1] = 1'b0;
        chk("start_beats_abort", stat[1], 1);
        chk("start_beats_abort_busy", busy[1], 1);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        chk("abort_settle_stat", stat[1], 0);

        // Reset mid-sweep at H=30.
        fill_random(0, 4095);
        load(0, 64);
        pulse_start(0);
        cyc = 0;
        while (!(stat[0] == 3'd1 && pos_h[0] == 32'd30 && axis[0] == 1'b0) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reached_pos30", pos_h[0], 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush();
        chk("midrst_pos_h", pos_h[0], PMIN);
        chk("midrst_pos_v", pos_v[0], PMIN);
        chk("midrst_max", max_v[0], 0);
        chk("midrst_stat", stat[0], 0);
        chk("midrst_busy", busy[0], 0);

        fill_random(1, 4095);
        run_sweep(1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
